instruction_fetch: RTL

Instruction-side producer for the decode stage. It takes decode's current program counter, issues word reads on the instruction bus, and holds returned words in a 2-entry tagged buffer. It returns the instruction plus a valid flag to decode, and speculatively prefetches the sequential next word (PC+4). The block sits between the instruction memory/bus and decode, closing the loop decode opens with its PC output.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_buffer.sv | 82 ++++++++
 rtl/instruction_fetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-side definitions: the NOOP encoding, FSM state encodings and the buffer slot layout.
package instruction_fetch_pkg;

    localparam logic [31:0] NOOP_INSN_DEFAULT = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_RESP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] data;
    } fetch_slot_t;

    // Tag of the sequentially next word; the 30-bit add wraps exactly like PC+4 modulo 2^32.
    function automatic logic [29:0] nextTag(input logic [29:0] tag);
        return tag + 30'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry tagged instruction store with a current-PC lookup, a PC+4 lookup and a single fill port.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [29:0] pcTag_i,
    input  logic [29:0] nextTag_i,
    output logic        pcHit_o,
    output logic [31:0] pcData_o,
    output logic        nextHit_o,
    input  logic        fillEn_i,
    input  logic [29:0] fillTag_i,
    input  logic [31:0] fillData_i
);

    fetch_slot_t slot_q [2];
    fetch_slot_t slot_d [2];
    logic        lru_q, lru_d;
    logic [1:0]  pcHitVec;
    logic [1:0]  nextHitVec;
    logic [1:0]  fillDupVec;
    logic        victim;

    always_comb begin
        pcHitVec[0]   = slot_q[0].valid && (slot_q[0].tag == pcTag_i);
        pcHitVec[1]   = slot_q[1].valid && (slot_q[1].tag == pcTag_i);
        nextHitVec[0] = slot_q[0].valid && (slot_q[0].tag == nextTag_i);
        nextHitVec[1] = slot_q[1].valid && (slot_q[1].tag == nextTag_i);
        fillDupVec[0] = slot_q[0].valid && (slot_q[0].tag == fillTag_i);
        fillDupVec[1] = slot_q[1].valid && (slot_q[1].tag == fillTag_i);
    end

    assign pcHit_o   = |pcHitVec;
    assign nextHit_o = |nextHitVec;
    assign pcData_o  = pcHitVec[1] ? slot_q[1].data : slot_q[0].data;

    // Never evict the word decode is looking at; an existing copy of the fill tag is overwritten in place.
    always_comb begin
        victim = lru_q;
        if (fillDupVec[0]) begin
            victim = 1'b0;
        end else if (fillDupVec[1]) begin
            victim = 1'b1;
        end else if (pcHitVec[0]) begin
            victim = 1'b1;
        end else if (pcHitVec[1]) begin
            victim = 1'b0;
        end else if (!slot_q[0].valid) begin
            victim = 1'b0;
        end else if (!slot_q[1].valid) begin
            victim = 1'b1;
        end
    end

    always_comb begin
        slot_d = slot_q;
        lru_d  = lru_q;
        if (flush_i) begin
            slot_d[0].valid = 1'b0;
            slot_d[1].valid = 1'b0;
        end else if (fillEn_i) begin
            slot_d[victim] = fetch_slot_t'{valid: 1'b1, tag: fillTag_i, data: fillData_i};
            lru_d          = ~victim;
        end else if (pcHit_o) begin
            lru_d = ~pcHitVec[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            lru_q     <= 1'b0;
        end else begin
            slot_q <= slot_d;
            lru_q  <= lru_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: looks up decode's PC in a small tagged buffer and keeps one bus read in flight
// to fill misses or prefetch the next sequential word.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter bit          PREFETCH  = 1'b1,
    parameter logic [31:0] NOOP_INSN = NOOP_INSN_DEFAULT
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_PC,
    input  logic        i_FLUSH,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_INSTRUCTION_VALID,
    output logic        o_IBUS_REQ,
    output logic [31:0] o_IBUS_ADDR,
    input  logic        i_IBUS_ACK,
    input  logic        i_IBUS_RVALID,
    input  logic [31:0] i_IBUS_RDATA
);

    fetch_state_e state_q, state_d;
    logic [29:0]  inflightTag_q, inflightTag_d;
    logic         dropPending_q, dropPending_d;
    logic [29:0]  pcTag;
    logic [29:0]  pcNextTag;
    logic         pcHit;
    logic         nextHit;
    logic [31:0]  hitData;
    logic         respDone;
    logic         fillEn;

    assign pcTag     = 30'(i_PC >> 2);
    assign pcNextTag = nextTag(pcTag);

    fetch_buffer u_buffer (
        .clk_i      (i_CLK),
        .rst_i      (i_RST),
        .flush_i    (i_FLUSH),
        .pcTag_i    (pcTag),
        .nextTag_i  (pcNextTag),
        .pcHit_o    (pcHit),
        .pcData_o   (hitData),
        .nextHit_o  (nextHit),
        .fillEn_i   (fillEn),
        .fillTag_i  (inflightTag_q),
        .fillData_i (i_IBUS_RDATA)
    );

    assign o_INSTRUCTION_VALID = pcHit;
    assign o_INSTRUCTION       = pcHit ? hitData : NOOP_INSN;
    // Gating with reset lets a pending request drop in the very cycle reset is raised.
    assign o_IBUS_REQ          = (state_q == FETCH_REQ) && !i_RST;
    assign o_IBUS_ADDR         = o_IBUS_REQ ? {inflightTag_q, 2'b00} : 32'h0;

    always_comb begin
        state_d       = state_q;
        inflightTag_d = inflightTag_q;
        respDone      = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (!pcHit) begin
                    inflightTag_d = pcTag;
                    state_d       = FETCH_REQ;
                end else if (PREFETCH && !nextHit) begin
                    inflightTag_d = pcNextTag;
                    state_d       = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (i_IBUS_ACK) begin
                    if (i_IBUS_RVALID) begin
                        respDone = 1'b1;
                        state_d  = FETCH_IDLE;
                    end else begin
                        state_d = FETCH_RESP;
                    end
                end
            end
            FETCH_RESP: begin
                if (i_IBUS_RVALID) begin
                    respDone = 1'b1;
                    state_d  = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        // A flush poisons whatever response is still owed; a flush on the response cycle itself just discards it.
        fillEn        = respDone && !dropPending_q && !i_FLUSH;
        dropPending_d = dropPending_q;
        if (respDone) begin
            dropPending_d = 1'b0;
        end else if (i_FLUSH && (state_q != FETCH_IDLE)) begin
            dropPending_d = 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q       <= FETCH_IDLE;
            inflightTag_q <= '0;
            dropPending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflightTag_q <= inflightTag_d;
            dropPending_q <= dropPending_d;
        end
    end

endmodule
